exec_arbiter: RTL and testbench

EXEC_ARBITER -- requirements
Module: exec_arbiter

---
 rtl/exec_arbiter.sv | 127 ++++++++++++
 tb/tb_exec_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_arbiter.sv
// Two-requester arbiter sharing one combinational Exec unit: IDLE -> EXEC -> RESP per operation.
// Define EXEC_ARB_FIXED_PRIO_EN for fixed requester-0 priority; otherwise round-robin.
module exec_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_op1,
  input  logic [DATA_W-1:0] req0_op2,
  input  logic [OP_W-1:0]   req0_operation,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_op1,
  input  logic [DATA_W-1:0] req1_op2,
  input  logic [OP_W-1:0]   req1_operation,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_out,
  output logic              rsp0_bcond,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_out,
  output logic              rsp1_bcond,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic [OP_W-1:0]   alu_operation,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_bcond,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic [DATA_W-1:0] op1_q, op1_d, op2_q, op2_d, res_q, res_d;
  logic [OP_W-1:0]   opc_q, opc_d;
  logic              bcond_q, bcond_d;
  logic              prio1, win, any, accept, rsp_take;

`ifdef EXEC_ARB_FIXED_PRIO_EN
  assign prio1 = 1'b0;
`else
  // ptr_q set means requester 1 wins the next tie.
  logic ptr_q, ptr_d;
  assign prio1 = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = ~win;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end
`endif

  assign any      = req0_valid | req1_valid;
  assign win      = (req0_valid & req1_valid) ? prio1 : req1_valid;
  // Ready is masked by reset so nothing appears accepted while reset is held.
  assign accept   = (state_q == IDLE) & any & ~reset;
  assign req0_ready = accept & ~win;
  assign req1_ready = accept & win;
  assign rsp_take = (state_q == RESP) & (gnt_q ? rsp1_ready : rsp0_ready);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    opc_d   = opc_q;
    res_d   = res_q;
    bcond_d = bcond_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = EXEC;
        gnt_d   = win;
        op1_d   = win ? req1_op1 : req0_op1;
        op2_d   = win ? req1_op2 : req0_op2;
        opc_d   = win ? req1_operation : req0_operation;
      end
      EXEC: begin
        state_d = RESP;
        res_d   = alu_out;
        bcond_d = alu_bcond;
      end
      RESP: if (rsp_take) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      opc_q   <= '0;
      res_q   <= '0;
      bcond_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      opc_q   <= opc_d;
      res_q   <= res_d;
      bcond_q <= bcond_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign rsp0_valid    = (state_q == RESP) & ~gnt_q;
  assign rsp1_valid    = (state_q == RESP) & gnt_q;
  assign rsp0_out      = rsp0_valid ? res_q : '0;
  assign rsp0_bcond    = rsp0_valid & bcond_q;
  assign rsp1_out      = rsp1_valid ? res_q : '0;
  assign rsp1_bcond    = rsp1_valid & bcond_q;
  assign alu_op1       = op1_q;
  assign alu_op2       = op2_q;
  assign alu_operation = opc_q;

endmodule

// File: tb/tb_exec_arbiter.sv
// Bench for exec_arbiter: directed vector table, grant/reset sequences, randomized run vs. model.
module tb_exec_arbiter;
  localparam int DW = 32;
  localparam int OW = 5;
`ifdef EXEC_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DW-1:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [OW-1:0] req0_operation, req1_operation;
  logic rsp0_valid, rsp0_ready, rsp0_bcond, rsp1_valid, rsp1_ready, rsp1_bcond;
  logic [DW-1:0] rsp0_out, rsp1_out, alu_op1, alu_op2, alu_out;
  logic [OW-1:0] alu_operation;
  logic alu_bcond, busy;

  always #5 clk = ~clk;

  // Behavioural Exec unit.
  always_comb begin
    alu_out   = alu_op1 + alu_op2;
    alu_bcond = (alu_op1 == alu_op2);
  end

  exec_arbiter #(.DATA_W(DW), .OP_W(OW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op1(req0_op1),
    .req0_op2(req0_op2), .req0_operation(req0_operation),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op1(req1_op1),
    .req1_op2(req1_op2), .req1_operation(req1_operation),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_out(rsp0_out), .rsp0_bcond(rsp0_bcond),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_out(rsp1_out), .rsp1_bcond(rsp1_bcond),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_operation(alu_operation),
    .alu_out(alu_out), .alu_bcond(alu_bcond), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req0_op1 = '0; req0_op2 = '0; req0_operation = '0; rsp0_ready = 0;
    req1_valid = 0; req1_op1 = '0; req1_op2 = '0; req1_operation = '0; rsp1_ready = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic v0, r0, v1, r1;
    logic [31:0] a0, b0, a1, b1;
    logic [4:0] o0, o1;
  } in_t;

  typedef struct {
    logic rdy0, rdy1, bsy, rv0, bc0, rv1, bc1;
    logic [31:0] out0, out1, x1, x2;
    logic [4:0] xo;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  function automatic in_t vin(input logic [31:0] v0, a0, b0, o0, r0, v1, a1, b1, o1, r1);
    in_t s;
    s.v0 = v0[0]; s.a0 = a0; s.b0 = b0; s.o0 = o0[4:0]; s.r0 = r0[0];
    s.v1 = v1[0]; s.a1 = a1; s.b1 = b1; s.o1 = o1[4:0]; s.r1 = r1[0];
    return s;
  endfunction

  function automatic exp_t vexp(input logic [31:0] rdy0, rdy1, bsy, rv0, out0, bc0,
                                rv1, out1, bc1, x1, x2, xo);
    exp_t e;
    e.rdy0 = rdy0[0]; e.rdy1 = rdy1[0]; e.bsy = bsy[0];
    e.rv0 = rv0[0]; e.out0 = out0; e.bc0 = bc0[0];
    e.rv1 = rv1[0]; e.out1 = out1; e.bc1 = bc1[0];
    e.x1 = x1; e.x2 = x2; e.xo = xo[4:0];
    return e;
  endfunction

  task automatic drive(input in_t s);
    req0_valid = s.v0; req0_op1 = s.a0; req0_op2 = s.b0; req0_operation = s.o0; rsp0_ready = s.r0;
    req1_valid = s.v1; req1_op1 = s.a1; req1_op2 = s.b1; req1_operation = s.o1; rsp1_ready = s.r1;
  endtask

  typedef struct packed {
    logic [31:0] o;
    logic        b;
  } res_t;

  vec_t tbl[16];
  res_t q0[$];
  res_t q1[$];
  logic [31:0] pool[6];

  initial begin
    idle_inputs();
    do_reset();

    // Reset state.
    #1;
    chk1("reset busy", busy, 1'b0);
    chk1("reset rsp0_valid", rsp0_valid, 1'b0);
    chkw("reset alu_op1", alu_op1, 32'h0);
    tick();

    // Directed table: single request, held response, wait-then-grant, tie-break.
    tbl[0] = '{vin(1, 7, 3, 2, 1, 0, 0, 0, 0, 0), vexp(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[1] = '{vin(0, 0, 0, 0, 1, 0, 0, 0, 0, 0), vexp(0, 0, 1, 0, 0, 0, 0, 0, 0, 7, 3, 2)};
    tbl[2] = '{vin(0, 0, 0, 0, 1, 0, 0, 0, 0, 0), vexp(0, 0, 1, 1, 'hA, 0, 0, 0, 0, 7, 3, 2)};
    tbl[3] = '{vin(0, 0, 0, 0, 0, 1, 'h55, 'h55, 'h1f, 0), vexp(0, 1, 0, 0, 0, 0, 0, 0, 0, 7, 3, 2)};
    tbl[4] = '{vin(1, 'h10, 'h20, 3, 0, 0, 0, 0, 0, 0),
               vexp(0, 0, 1, 0, 0, 0, 0, 0, 0, 'h55, 'h55, 'h1f)};
    for (int k = 5; k <= 9; k++)
      tbl[k] = '{vin(1, 'h10, 'h20, 3, 0, 0, 0, 0, 0, 0),
                 vexp(0, 0, 1, 0, 0, 0, 1, 'hAA, 1, 'h55, 'h55, 'h1f)};
    tbl[10] = '{vin(1, 'h10, 'h20, 3, 0, 0, 0, 0, 0, 1),
                vexp(0, 0, 1, 0, 0, 0, 1, 'hAA, 1, 'h55, 'h55, 'h1f)};
    tbl[11] = '{vin(1, 'h10, 'h20, 3, 1, 1, 1, 2, 4, 0),
                vexp(1, 0, 0, 0, 0, 0, 0, 0, 0, 'h55, 'h55, 'h1f)};
    tbl[12] = '{vin(1, 'h10, 'h20, 3, 1, 1, 1, 2, 4, 0),
                vexp(0, 0, 1, 0, 0, 0, 0, 0, 0, 'h10, 'h20, 3)};
    tbl[13] = '{vin(1, 'h10, 'h20, 3, 1, 1, 1, 2, 4, 0),
                vexp(0, 0, 1, 1, 'h30, 0, 0, 0, 0, 'h10, 'h20, 3)};
    tbl[14] = '{vin(1, 'h10, 'h20, 3, 1, 1, 1, 2, 4, 1),
                vexp(FIXED ? 1 : 0, FIXED ? 0 : 1, 0, 0, 0, 0, 0, 0, 0, 'h10, 'h20, 3)};
    tbl[15] = '{vin(1, 'h10, 'h20, 3, 1, 1, 1, 2, 4, 1),
                vexp(0, 0, 1, 0, 0, 0, 0, 0, 0, FIXED ? 'h10 : 1, FIXED ? 'h20 : 2, FIXED ? 3 : 4)};

    for (int k = 0; k < 16; k++) begin
      drive(tbl[k].i);
      #1;
      chk1($sformatf("row%0d req0_ready", k), req0_ready, tbl[k].e.rdy0);
      chk1($sformatf("row%0d req1_ready", k), req1_ready, tbl[k].e.rdy1);
      chk1($sformatf("row%0d busy", k), busy, tbl[k].e.bsy);
      chk1($sformatf("row%0d rsp0_valid", k), rsp0_valid, tbl[k].e.rv0);
      chkw($sformatf("row%0d rsp0_out", k), rsp0_out, tbl[k].e.out0);
      chk1($sformatf("row%0d rsp0_bcond", k), rsp0_bcond, tbl[k].e.bc0);
      chk1($sformatf("row%0d rsp1_valid", k), rsp1_valid, tbl[k].e.rv1);
      chkw($sformatf("row%0d rsp1_out", k), rsp1_out, tbl[k].e.out1);
      chk1($sformatf("row%0d rsp1_bcond", k), rsp1_bcond, tbl[k].e.bc1);
      chkw($sformatf("row%0d alu_op1", k), alu_op1, tbl[k].e.x1);
      chkw($sformatf("row%0d alu_op2", k), alu_op2, tbl[k].e.x2);
      chkw($sformatf("row%0d alu_operation", k), 32'(alu_operation), 32'(tbl[k].e.xo));
      tick();
    end

    // Both requesters valid from reset, responses taken at once: a grant every 3 cycles.
    do_reset();
    req0_valid = 1; req0_op1 = 1; req0_op2 = 1; rsp0_ready = 1;
    req1_valid = 1; req1_op1 = 2; req1_op2 = 2; rsp1_ready = 1;
    for (int c = 0; c < 12; c++) begin
      logic g;
      #1;
      g = FIXED ? 1'b0 : ((c / 3) % 2 == 1);
      if (c % 3 == 0) begin
        chk1($sformatf("alt%0d req0_ready", c), req0_ready, ~g);
        chk1($sformatf("alt%0d req1_ready", c), req1_ready, g);
      end else begin
        chk1($sformatf("alt%0d req0_ready", c), req0_ready, 1'b0);
        chk1($sformatf("alt%0d req1_ready", c), req1_ready, 1'b0);
      end
      tick();
    end

    // Reset during EXEC abandons the operation and restores requester-0 priority.
    do_reset();
    req0_valid = 1; req0_op1 = 9; req0_op2 = 9; rsp0_ready = 1;
    #1;
    chk1("rexec accept", req0_ready, 1'b1);
    tick();
    req0_valid = 0;
    #1;
    chk1("rexec busy", busy, 1'b1);
    #2;
    reset = 1'b1;
    req0_valid = 1; req1_valid = 1; rsp1_ready = 1;
    #1;
    chk1("rst req0_ready", req0_ready, 1'b0);
    chk1("rst req1_ready", req1_ready, 1'b0);
    chk1("rst busy", busy, 1'b0);
    chk1("rst rsp0_valid", rsp0_valid, 1'b0);
    chk1("rst rsp1_valid", rsp1_valid, 1'b0);
    chkw("rst rsp0_out", rsp0_out, 32'h0);
    chk1("rst rsp0_bcond", rsp0_bcond, 1'b0);
    chkw("rst rsp1_out", rsp1_out, 32'h0);
    chk1("rst rsp1_bcond", rsp1_bcond, 1'b0);
    chkw("rst alu_op1", alu_op1, 32'h0);
    chkw("rst alu_op2", alu_op2, 32'h0);
    chkw("rst alu_operation", 32'(alu_operation), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    req0_valid = 0; req1_valid = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk1($sformatf("post-rst%0d rsp0_valid", c), rsp0_valid, 1'b0);
      chk1($sformatf("post-rst%0d rsp1_valid", c), rsp1_valid, 1'b0);
      chk1($sformatf("post-rst%0d busy", c), busy, 1'b0);
      tick();
    end
    req0_valid = 1; req1_valid = 1;
    #1;
    chk1("post-rst grant req0", req0_ready, 1'b1);
    chk1("post-rst no req1", req1_ready, 1'b0);

    // Randomized run against a transaction-level model.
    pool = '{32'h0, 32'h1, 32'h5, 32'h55, 32'hFFFF_FFFF, 32'h8000_0000};
    do_reset();
    begin
      int acc = 0, done = 0, cyc = 0, ac = 0;
      bit mb = 0, own = 0, last = 1;
      logic [31:0] c1 = '0, c2 = '0;
      logic [4:0] co = '0;
      while ((acc < 18 || mb) && cyc < 3000) begin
        logic [31:0] t0, t1;
        logic free, anyv, w, inresp;
        t0 = $urandom; t1 = $urandom;
        req0_valid = (acc < 18) ? t0[8] : 1'b0;
        req1_valid = (acc < 18) ? t1[8] : 1'b0;
        req0_op1 = pool[$urandom_range(0, 5)]; req0_op2 = pool[$urandom_range(0, 5)];
        req1_op1 = pool[$urandom_range(0, 5)]; req1_op2 = pool[$urandom_range(0, 5)];
        req0_operation = t0[4:0]; req1_operation = t1[4:0];
        rsp0_ready = ($urandom_range(0, 3) != 0);
        rsp1_ready = ($urandom_range(0, 3) != 0);
        #1;
        free   = !mb;
        anyv   = req0_valid || req1_valid;
        w      = (req0_valid && req1_valid) ? (FIXED ? 1'b0 : !last) : req1_valid;
        inresp = mb && (cyc - ac >= 2);
        chk1("rnd req0_ready", req0_ready, free && anyv && !w);
        chk1("rnd req1_ready", req1_ready, free && anyv && w);
        chk1("rnd busy", busy, mb);
        chk1("rnd rsp0_valid", rsp0_valid, inresp && !own);
        chk1("rnd rsp1_valid", rsp1_valid, inresp && own);
        if (mb) begin
          chkw("rnd alu_op1", alu_op1, c1);
          chkw("rnd alu_op2", alu_op2, c2);
          chkw("rnd alu_operation", 32'(alu_operation), 32'(co));
        end
        if (inresp) begin
          res_t f;
          chk1("rnd response expected", (own ? q1.size() : q0.size()) > 0, 1'b1);
          f = own ? (q1.size() > 0 ? q1[0] : '0) : (q0.size() > 0 ? q0[0] : '0);
          chkw("rnd rsp_out", own ? rsp1_out : rsp0_out, f.o);
          chk1("rnd rsp_bcond", own ? rsp1_bcond : rsp0_bcond, f.b);
        end
        if (free && anyv) begin
          c1 = w ? req1_op1 : req0_op1;
          c2 = w ? req1_op2 : req0_op2;
          co = w ? req1_operation : req0_operation;
          if (w) q1.push_back('{c1 + c2, c1 == c2});
          else   q0.push_back('{c1 + c2, c1 == c2});
          mb = 1; ac = cyc; own = w; last = w; acc++;
        end else if (inresp && (own ? rsp1_ready : rsp0_ready)) begin
          if (own && q1.size() > 0) void'(q1.pop_front());
          if (!own && q0.size() > 0) void'(q0.pop_front());
          mb = 0; done++;
        end
        tick();
        cyc++;
      end
      chk1("rnd within cycle budget", cyc < 3000, 1'b1);
      chkw("rnd responses", done, 32'd18);
      chk1("rnd q0 drained", q0.size() == 0, 1'b1);
      chk1("rnd q1 drained", q1.size() == 0, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
